bsg_clz_shared_arb: RTL and testbench
=====================================

Name: bsg_clz_shared_arb

Overview:
- Shares one leading-zero-count/normalize datapath among num_req_p requesters.
- Round-robin arbiter selects one requester per cycle.
- The winner's operand is counted and left-normalized; the result is held in a single-entry output register tagged with the requester id.
- Sits between several FP/fixed-point lanes and a shared normalization stage; throughput is 1 result per cycle, latency 1 cycle.

Parameters:
- width_p, 16, operand width in bits.
- num_req_p, 4, number of requesters (>=2).
- lg_num_req_lp, max(1, clog2(num_req_p)), derived: tag width.
- clz_width_lp, clog2(width_p+1), derived: count width (5 for 16).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- v_i  in  num_req_p  per-requester operand valid.
- data_i  in  num_req_p*width_p  operands; requester k occupies bits [k*width_p +: width_p].
- ready_o  out  num_req_p  per-requester accept; handshake on v_i[k] & ready_o[k].
- v_o  out  1  result valid.
- clz_o  out  clz_width_lp  leading zeros counted from MSB of the winning operand.
- norm_o  out  width_p  operand << clz_o.
- zero_o  out  1  operand was all zeros.
- tag_o  out  lg_num_req_lp  index of the requester that produced the result.
- yumi_i  in  1  consumer takes result; legal only when v_o=1.

Behaviour:
- State:
  - ptr_r: round-robin priority pointer, lg_num_req_lp bits.
  - Output register: v_r, clz_r, norm_r, zero_r, tag_r. Outputs are driven directly from these registers.
- Reset: at a clock edge with reset_n_i=0, v_r<=0 and ptr_r<=0; other output fields are don't-care.
  - While reset_n_i=0, ready_o is forced to all zeros.
  - Reset mid-operation discards any held result; v_o is low in the cycle after the reset edge.
- can_accept = ~v_r | yumi_i (combinational).
- Arbitration:
  - Search v_i starting at index ptr_r, ascending and wrapping modulo num_req_p; the first set bit wins (index g).
  - ready_o is one-hot: ready_o[g] = can_accept & reset_n_i; all other bits 0.
  - If v_i=0, ready_o=0.
  - ready_o may depend combinationally on v_i and yumi_i. v_i must not depend on ready_o.
- Handshake at edge (v_i[g] & ready_o[g]):
  - v_r<=1, tag_r<=g.
  - clz_r<=count of leading zeros of data_i[g].
  - norm_r<=data_i[g]<<count.
  - zero_r<=(data_i[g]==0).
  - ptr_r<=(g+1) mod num_req_p. The pointer moves only on a handshake.
- yumi_i with no handshake in the same cycle: v_r<=0.
- yumi_i and handshake in the same cycle: the new result replaces the old one; v_r stays 1. This gives back-to-back 1/cycle throughput.
- No yumi_i while v_r=1: the output register holds all fields stable and ready_o=0.
- Zero operand: clz_o=width_p (16), norm_o=0, zero_o=1.
- MSB set: clz_o=0, norm_o=operand, zero_o=0.
- num_req_p not a power of two: the pointer wraps from num_req_p-1 to 0. Index values >= num_req_p are never produced.
- Fairness: a requester holding v_i continuously is granted within num_req_p handshakes.
- Assertions: yumi_i & ~v_o is an error; ready_o is onehot0.

Decomposition:
- Package bsg_clz_arb_pkg holds the clz_width and tag_width helper functions.
- Natural sub-module: bsg_counting_leading_zeros, reused as the count unit (width_p=16).
  - Normalization shift and round-robin logic stay inline; the arbiter is small enough not to warrant its own module.

Test Plan:
- Reset then idle: hold reset_n_i=0 for 3 cycles with v_i=4'b1111 -> ready_o=0, v_o=0. Release with v_i=0 -> v_o stays 0.
- Single request: v_i=4'b0100, data_i[2]=16'h00F0, yumi_i=1 when v_o -> ready_o=4'b0100; next cycle v_o=1, clz_o=8, norm_o=16'hF000, zero_o=0, tag_o=2; ptr then 3.
- Round-robin: v_i=4'b1111 held, yumi_i tied to v_o, operands k+1 -> grants in order 0,1,2,3,0 on consecutive cycles; tags 0,1,2,3,0; v_o high every cycle after the first.
- Backpressure: result pending with yumi_i=0 for 5 cycles, v_i=4'b0011 -> ready_o=0 and outputs stable for those cycles. Assert yumi_i -> same-cycle grant to the requester at ptr, new result next cycle.
- Zero and MSB operands: data 16'h0000 -> clz_o=16, norm_o=0, zero_o=1. Data 16'h8001 -> clz_o=0, norm_o=16'h8001. Data 16'h0001 -> clz_o=15, norm_o=16'h8000.
- Reset mid-stream: v_o=1 with yumi_i=0, pulse reset_n_i=0 for 1 cycle -> v_o=0 the next cycle. The next grant goes to requester 0 even if ptr was 2.

Source files
------------

// File: rtl/bsg_clz_arb_pkg.sv
// Width helpers shared by the CLZ arbiter, its interface and the count unit.
package bsg_clz_arb_pkg;

   function automatic int clz_width(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic int tag_width(input int num_req);
      return (num_req <= 2) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/bsg_clz_shared_arb_if.sv
// Requester/consumer bundle of the shared leading-zero-count/normalize stage.
interface bsg_clz_shared_arb_if
   import bsg_clz_arb_pkg::*;
#(
   parameter int width_p   = 16,
   parameter int num_req_p = 4
);
   localparam int lg_num_req_lp = tag_width(num_req_p);
   localparam int clz_width_lp  = clz_width(width_p);

   logic [num_req_p-1:0]         v_i;
   logic [num_req_p*width_p-1:0] data_i;
   logic [num_req_p-1:0]         ready_o;
   logic                         v_o;
   logic [clz_width_lp-1:0]      clz_o;
   logic [width_p-1:0]           norm_o;
   logic                         zero_o;
   logic [lg_num_req_lp-1:0]     tag_o;
   logic                         yumi_i;

   modport slave (
      input  v_i, data_i, yumi_i,
      output ready_o, v_o, clz_o, norm_o, zero_o, tag_o
   );

   modport master (
      output v_i, data_i, yumi_i,
      input  ready_o, v_o, clz_o, norm_o, zero_o, tag_o
   );
endinterface

// File: rtl/bsg_counting_leading_zeros.sv
// Combinational leading-zero count from the MSB; an all-zero input yields width_p.
module bsg_counting_leading_zeros
   import bsg_clz_arb_pkg::*;
#(
   parameter int width_p = 16
)(
   input  logic [width_p-1:0]                    a_i,
   output logic [clz_width(width_p)-1:0]         num_zero_o
);
   localparam int cw_lp = clz_width(width_p);

   // Ascending scan: the highest set bit is seen last and decides the count.
   always_comb begin
      num_zero_o = cw_lp'(width_p);
      for (int i = 0; i < width_p; i++)
         if (a_i[i]) num_zero_o = cw_lp'(width_p - 1 - i);
   end
endmodule

// File: rtl/bsg_clz_shared_arb.sv
// Round-robin shared leading-zero-count/normalize unit with a single-entry
// tagged output register; 1 result per cycle, 1 cycle latency.
module bsg_clz_shared_arb
   import bsg_clz_arb_pkg::*;
#(
   parameter int width_p   = 16,
   parameter int num_req_p = 4
)(
   input logic                  clk_i,
   input logic                  reset_n_i,
   bsg_clz_shared_arb_if.slave  io
);
   localparam int lg_num_req_lp = tag_width(num_req_p);
   localparam int clz_width_lp  = clz_width(width_p);

   logic [lg_num_req_lp-1:0] ptr_r, ptr_next, grant;
   logic                     found, can_accept, hs;
   logic [width_p-1:0]       sel_data, norm;
   logic [clz_width_lp-1:0]  clz;
   logic [num_req_p-1:0]     ready;
   int                       idx;

   logic                     v_r, zero_r;
   logic [clz_width_lp-1:0]  clz_r;
   logic [width_p-1:0]       norm_r;
   logic [lg_num_req_lp-1:0] tag_r;

   assign can_accept = ~v_r | io.yumi_i;

   // Search starts at ptr_r and wraps modulo num_req_p, so non-power-of-two
   // requester counts never produce an out-of-range index.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 0; k < num_req_p; k++) begin
         idx = int'(ptr_r) + k;
         if (idx >= num_req_p) idx = idx - num_req_p;
         if (!found && io.v_i[idx]) begin
            found = 1'b1;
            grant = lg_num_req_lp'(idx);
         end
      end
   end

   assign hs = found & can_accept & reset_n_i;

   always_comb begin
      ready = '0;
      if (hs) ready[grant] = 1'b1;
   end

   assign ptr_next = (int'(grant) == num_req_p - 1) ? '0 : grant + 1'b1;
   assign sel_data = io.data_i[int'(grant)*width_p +: width_p];

   bsg_counting_leading_zeros #(.width_p(width_p)) clz_u (
      .a_i        (sel_data),
      .num_zero_o (clz)
   );

   assign norm = sel_data << clz;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         v_r   <= 1'b0;
         ptr_r <= '0;
      end else if (hs) begin
         v_r   <= 1'b1;
         ptr_r <= ptr_next;
      end else if (io.yumi_i) begin
         v_r   <= 1'b0;
      end
   end

   // Payload needs no reset; it is only meaningful while v_r is set.
   always_ff @(posedge clk_i) begin
      if (hs) begin
         clz_r  <= clz;
         norm_r <= norm;
         zero_r <= (sel_data == '0);
         tag_r  <= grant;
      end
   end

   assign io.ready_o = ready;
   assign io.v_o     = v_r;
   assign io.clz_o   = clz_r;
   assign io.norm_o  = norm_r;
   assign io.zero_o  = zero_r;
   assign io.tag_o   = tag_r;

   a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(io.yumi_i && !v_r));
   a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(io.ready_o));

endmodule

// File: tb/tb_bsg_clz_shared_arb.sv
// Self-checking bench: directed tables/sequences plus randomized traffic
// compared against a queue-free behavioural model of the arbiter.
module tb_bsg_clz_shared_arb;
   localparam int W = 16;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   bsg_clz_shared_arb_if #(.width_p(W), .num_req_p(N)) io ();

   bsg_clz_shared_arb #(.width_p(W), .num_req_p(N)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .io        (io.slave)
   );

   typedef struct {
      int          req;
      logic [15:0] data;
      int          exp_clz;
      logic [15:0] exp_norm;
      logic        exp_zero;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int clz_ref(input logic [15:0] d);
      int n = 0;
      while (n < 16 && d[15-n] == 1'b0) n++;
      return n;
   endfunction

   task automatic set_data(input int k, input logic [15:0] d);
      io.data_i[k*W +: W] = d;
   endtask

   task automatic drain();
      io.v_i = '0;
      if (io.v_o) begin
         io.yumi_i = 1'b1;
         tick();
         io.yumi_i = 1'b0;
      end
   endtask

   task automatic do_reset();
      io.v_i = '0;
      io.yumi_i = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   // model state
   int          m_ptr;
   logic        m_valid;
   int          m_tag;
   logic [15:0] m_data;

   initial begin
      tbl[0] = '{0, 16'h0000, 16, 16'h0000, 1'b1};
      tbl[1] = '{1, 16'h8001,  0, 16'h8001, 1'b0};
      tbl[2] = '{2, 16'h0001, 15, 16'h8000, 1'b0};
      tbl[3] = '{3, 16'h00F0,  8, 16'hF000, 1'b0};
      tbl[4] = '{0, 16'h1234,  3, 16'h91A0, 1'b0};
      tbl[5] = '{1, 16'hFFFF,  0, 16'hFFFF, 1'b0};

      reset_n   = 1'b0;
      io.v_i    = '0;
      io.data_i = '0;
      io.yumi_i = 1'b0;

      // reset with all requesters asserting
      io.v_i = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         #1 chk("reset_ready", io.ready_o, 0);
         tick();
         chk("reset_v", io.v_o, 0);
      end
      reset_n = 1'b1;
      io.v_i  = '0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("idle_v", io.v_o, 0);
      end

      // single request
      set_data(2, 16'h00F0);
      io.v_i = 4'b0100;
      #1 chk("single_ready", io.ready_o, 4'b0100);
      tick();
      io.v_i = '0;
      chk("single_v", io.v_o, 1);
      chk("single_clz", io.clz_o, 8);
      chk("single_norm", io.norm_o, 16'hF000);
      chk("single_zero", io.zero_o, 0);
      chk("single_tag", io.tag_o, 2);
      drain();
      chk("single_drained", io.v_o, 0);
      io.v_i = 4'b1111;
      #1 chk("single_ptr3", io.ready_o, 4'b1000);
      tick();
      drain();

      // round robin, yumi tied to v_o
      do_reset();
      for (int k = 0; k < N; k++) set_data(k, 16'(k + 1));
      io.v_i = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         io.yumi_i = io.v_o;
         #1 chk("rr_ready", io.ready_o, 64'(1 << (c % N)));
         tick();
         chk("rr_v", io.v_o, 1);
         chk("rr_tag", io.tag_o, c % N);
         chk("rr_clz", io.clz_o, clz_ref(16'((c % N) + 1)));
      end
      io.yumi_i = 1'b0;

      // backpressure: result from requester 0 held, ptr is now 1
      io.v_i = 4'b0011;
      for (int c = 0; c < 5; c++) begin
         #1 chk("bp_ready", io.ready_o, 0);
         tick();
         chk("bp_v", io.v_o, 1);
         chk("bp_tag", io.tag_o, 0);
         chk("bp_norm", io.norm_o, 16'h8000);
         chk("bp_clz", io.clz_o, 15);
      end
      io.yumi_i = 1'b1;
      #1 chk("bp_release_ready", io.ready_o, 4'b0010);
      tick();
      io.yumi_i = 1'b0;
      io.v_i = '0;
      chk("bp_new_v", io.v_o, 1);
      chk("bp_new_tag", io.tag_o, 1);
      chk("bp_new_clz", io.clz_o, 14);
      drain();

      // operand table
      foreach (tbl[i]) begin
         set_data(tbl[i].req, tbl[i].data);
         io.v_i = 4'(1 << tbl[i].req);
         #1 chk("tbl_ready", io.ready_o, 64'(1 << tbl[i].req));
         tick();
         io.v_i = '0;
         chk("tbl_v", io.v_o, 1);
         chk("tbl_tag", io.tag_o, tbl[i].req);
         chk("tbl_clz", io.clz_o, tbl[i].exp_clz);
         chk("tbl_norm", io.norm_o, tbl[i].exp_norm);
         chk("tbl_zero", io.zero_o, tbl[i].exp_zero);
         drain();
      end

      // reset mid-stream while a result is pending and ptr is 2
      do_reset();
      io.v_i = 4'b0010;
      tick();
      io.v_i = '0;
      chk("mid_v_before", io.v_o, 1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mid_v_after", io.v_o, 0);
      io.v_i = 4'b1111;
      #1 chk("mid_ready_req0", io.ready_o, 4'b0001);
      tick();
      chk("mid_tag", io.tag_o, 0);
      drain();

      // randomized traffic against the model
      do_reset();
      m_ptr = 0;
      m_valid = 1'b0;
      m_tag = 0;
      m_data = '0;
      for (int c = 0; c < 400; c++) begin
         logic [15:0] d [N];
         logic [N-1:0] v;
         logic y;
         int g;
         logic [N-1:0] exp_ready;
         v = 4'($urandom);
         for (int k = 0; k < N; k++) begin
            d[k] = 16'($urandom) >> $urandom_range(0, 16);
            set_data(k, d[k]);
         end
         y = m_valid && ($urandom_range(0, 3) != 0);
         io.v_i = v;
         io.yumi_i = y;
         g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         exp_ready = (g >= 0 && (!m_valid || y)) ? 4'(1 << g) : 4'b0;
         #1 chk("rnd_ready", io.ready_o, exp_ready);
         tick();
         if (exp_ready != 0) begin
            m_valid = 1'b1;
            m_tag = g;
            m_data = d[g];
            m_ptr = (g + 1) % N;
         end else if (y) begin
            m_valid = 1'b0;
         end
         chk("rnd_v", io.v_o, m_valid);
         if (m_valid) begin
            chk("rnd_tag", io.tag_o, m_tag);
            chk("rnd_clz", io.clz_o, clz_ref(m_data));
            chk("rnd_norm", io.norm_o, (m_data == 0) ? 16'h0 : 16'(m_data * (2 ** clz_ref(m_data))));
            chk("rnd_zero", io.zero_o, m_data == 0);
         end
      end
      io.v_i = '0;
      io.yumi_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
